// File: rtl/regfile_access_ctrl_pkg.sv
// regfile_pkg: shared op encodings, FSM states and default widths for the register file access controller
package regfile_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 4;
    localparam int RF_NREGS  = 2**RF_ADDR_W;
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ2 = 2'b01,
        OP_FILL  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RESP
    } state_e;
endpackage

// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: command/response channels plus register file strobe bus
// slave modport: controller side (takes cmd_*, rsp_ready, rf_op*; drives the rest)
// master modport: requester and register file side
interface regfile_access_ctrl_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr_a;
    logic [ADDR_W-1:0] cmd_addr_b;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_op;
    logic [DATA_W-1:0] rsp_data_a;
    logic [DATA_W-1:0] rsp_data_b;
    logic              busy;
    logic              rf_en;
    logic              rf_wr;
    logic              rf_rd;
    logic [DATA_W-1:0] rf_ip1;
    logic [ADDR_W-1:0] rf_sel_i1;
    logic [ADDR_W-1:0] rf_sel_o1;
    logic [ADDR_W-1:0] rf_sel_o2;
    logic [DATA_W-1:0] rf_op1;
    logic [DATA_W-1:0] rf_op2;
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready, rf_op1, rf_op2,
        output cmd_ready, rsp_valid, rsp_op, rsp_data_a, rsp_data_b, busy,
        output rf_en, rf_wr, rf_rd, rf_ip1, rf_sel_i1, rf_sel_o1, rf_sel_o2
    );
    modport master (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready, rf_op1, rf_op2,
        input  cmd_ready, rsp_valid, rsp_op, rsp_data_a, rsp_data_b, busy,
        input  rf_en, rf_wr, rf_rd, rf_ip1, rf_sel_i1, rf_sel_o1, rf_sel_o2
    );
endinterface

// File: rtl/regfile_access_ctrl_sweep_cnt.sv
// regfile_sweep_cnt: address/data/count generator driving the write sweep
// load_i latches start address, start data, target count and data-increment mode;
// step_i advances one write; done_o is high while the current write is the last one
module regfile_sweep_cnt
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              inc_data_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W:0]   target_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              done_o
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W:0]   count_q, count_d, target_q, target_d;
    logic              inc_q, inc_d;
    always_comb begin
        addr_d   = load_i ? addr_i : step_i ? addr_q + ADDR_W'(1) : addr_q;
        data_d   = load_i ? data_i : (step_i && inc_q) ? data_q + DATA_W'(1) : data_q;
        count_d  = load_i ? '0 : step_i ? count_q + (ADDR_W+1)'(1) : count_q;
        target_d = load_i ? target_i : target_q;
        inc_d    = load_i ? inc_data_i : inc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            data_q   <= '0;
            count_q  <= '0;
            target_q <= '0;
            inc_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            count_q  <= count_d;
            target_q <= target_d;
            inc_q    <= inc_d;
        end
    end
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign count_o = count_q;
    assign done_o  = count_q + (ADDR_W+1)'(1) == target_q;
endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequences WRITE/READ2/FILL/CLEAR commands onto the 16x32 register file strobes
// clk/rst: clock and synchronous active-high reset; bus (slave): cmd and rsp valid/ready
// channels, busy flag, and the rf_* enable/strobe/select/data lines
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int RD_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    regfile_access_ctrl_if.slave bus
);
    localparam int NREGS = 2**ADDR_W;
    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] sel_o1_q, sel_o1_d, sel_o2_q, sel_o2_d;
    logic [1:0]        wait_q, wait_d;
    logic [DATA_W-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
    logic              load, step, cnt_done;
    logic [ADDR_W-1:0] span, cnt_addr;
    logic [DATA_W-1:0] cnt_data;
    logic [ADDR_W:0]   ld_target, cnt_count;
    // FILL span is taken modulo NREGS before widening so a wrapping range stays short
    assign span      = bus.cmd_addr_b - bus.cmd_addr_a;
    assign ld_target = bus.cmd_op == OP_WRITE ? (ADDR_W+1)'(1) :
                       bus.cmd_op == OP_FILL  ? (ADDR_W+1)'(span) + (ADDR_W+1)'(1) :
                                                (ADDR_W+1)'(NREGS);
    regfile_sweep_cnt #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sweep (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .step_i     (step),
        .inc_data_i (bus.cmd_op == OP_FILL),
        .addr_i     (bus.cmd_op == OP_CLEAR ? '0 : bus.cmd_addr_a),
        .data_i     (bus.cmd_op == OP_CLEAR ? '0 : bus.cmd_data),
        .target_i   (ld_target),
        .addr_o     (cnt_addr),
        .data_o     (cnt_data),
        .count_o    (cnt_count),
        .done_o     (cnt_done)
    );
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sel_o1_d = sel_o1_q;
        sel_o2_d = sel_o2_q;
        wait_d   = wait_q;
        rsp_a_d  = rsp_a_q;
        rsp_b_d  = rsp_b_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                op_d     = bus.cmd_op;
                sel_o1_d = bus.cmd_addr_a;
                sel_o2_d = bus.cmd_addr_b;
                load     = bus.cmd_op != OP_READ2;
                state_d  = bus.cmd_op == OP_READ2 ? S_RD_ISSUE : S_WR;
            end
            S_WR: begin
                step = 1'b1;
                if (cnt_done) begin
                    rsp_a_d = DATA_W'(cnt_count) + DATA_W'(1);
                    rsp_b_d = '0;
                    state_d = S_RESP;
                end
            end
            S_RD_ISSUE: begin
                wait_d  = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                wait_d = wait_q + 2'd1;
                if (wait_q == 2'(RD_LAT - 1)) begin
                    rsp_a_d = bus.rf_op1;
                    rsp_b_d = bus.rf_op2;
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = bus.rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sel_o1_q <= '0;
            sel_o2_q <= '0;
            wait_q   <= '0;
            rsp_a_q  <= '0;
            rsp_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sel_o1_q <= sel_o1_d;
            sel_o2_q <= sel_o2_d;
            wait_q   <= wait_d;
            rsp_a_q  <= rsp_a_d;
            rsp_b_q  <= rsp_b_d;
        end
    end
    assign bus.cmd_ready  = state_q == S_IDLE;
    assign bus.busy       = state_q != S_IDLE;
    assign bus.rsp_valid  = state_q == S_RESP;
    assign bus.rsp_op     = op_q;
    assign bus.rsp_data_a = rsp_a_q;
    assign bus.rsp_data_b = rsp_b_q;
    assign bus.rf_en      = state_q inside {S_WR, S_RD_ISSUE, S_RD_WAIT};
    assign bus.rf_wr      = state_q == S_WR;
    assign bus.rf_rd      = state_q == S_RD_ISSUE;
    assign bus.rf_ip1     = cnt_data;
    assign bus.rf_sel_i1  = cnt_addr;
    assign bus.rf_sel_o1  = sel_o1_q;
    assign bus.rf_sel_o2  = sel_o2_q;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: scoreboard bench driving two controllers (RD_LAT 1 and 3) with the same directed commands
module tb_regfile_access_ctrl;
    import regfile_pkg::*;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          tacc;
        int          lat;
    } exp_t;
    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int checks = 0;
    int errors = 0;
    exp_t eq [2][$];
    wr_t  wq [2][$];
    logic [1:0]  vld = 2'b00;
    logic [1:0]  c_op = 2'b00;
    logic [3:0]  c_a = 4'd0, c_b = 4'd0;
    logic [31:0] c_d = 32'd0;
    logic        rrdy = 1'b1;
    logic        rdy [2], bsy [2], rv [2], en [2], wr [2], rd [2];
    logic [1:0]  rop [2];
    logic [31:0] ra [2], rb [2], ip [2];
    logic [3:0]  si [2], so1 [2], so2 [2];
    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = g == 0 ? 1 : 3;
        logic [31:0] mem [16];
        int k = 0;
        regfile_access_ctrl_if #(.DATA_W(32), .ADDR_W(4)) bus ();
        regfile_access_ctrl #(.DATA_W(32), .ADDR_W(4), .RD_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign bus.cmd_valid  = vld[g];
        assign bus.cmd_op     = c_op;
        assign bus.cmd_addr_a = c_a;
        assign bus.cmd_addr_b = c_b;
        assign bus.cmd_data   = c_d;
        assign bus.rsp_ready  = rrdy;
        assign bus.rf_op1     = k == LAT ? mem[bus.rf_sel_o1] : 32'hDEAD_BEEF;
        assign bus.rf_op2     = k == LAT ? mem[bus.rf_sel_o2] : 32'hDEAD_BEEF;
        assign rdy[g] = bus.cmd_ready;
        assign bsy[g] = bus.busy;
        assign rv[g]  = bus.rsp_valid;
        assign rop[g] = bus.rsp_op;
        assign ra[g]  = bus.rsp_data_a;
        assign rb[g]  = bus.rsp_data_b;
        assign en[g]  = bus.rf_en;
        assign wr[g]  = bus.rf_wr;
        assign rd[g]  = bus.rf_rd;
        assign ip[g]  = bus.rf_ip1;
        assign si[g]  = bus.rf_sel_i1;
        assign so1[g] = bus.rf_sel_o1;
        assign so2[g] = bus.rf_sel_o2;
        always @(posedge clk) begin
            if (bus.rf_en && bus.rf_wr) mem[bus.rf_sel_i1] <= bus.rf_ip1;
            k <= bus.rf_rd ? 1 : (k != 0 && k < LAT) ? k + 1 : 0;
        end
    end
    logic [1:0]  seen = 2'b00;
    int          tfirst [2];
    logic [1:0]  hop [2];
    logic [31:0] ha [2], hb [2];
    wr_t         w;
    exp_t        e;
    always @(negedge clk) begin
        if (rst) seen = 2'b00;
        for (int g = 0; g < 2; g++) begin
            if (wr[g] || rd[g]) begin
                checks++;
                if (!en[g] || (wr[g] && rd[g])) begin
                    errors++;
                    $display("FAIL strobe lane%0d en=%b wr=%b rd=%b required en=1 with wr/rd exclusive", g, en[g], wr[g], rd[g]);
                end
            end
            if (wr[g]) begin
                checks++;
                if (wq[g].size() == 0) begin
                    errors++;
                    $display("FAIL wr_extra lane%0d addr=%0d data=%h required no write", g, si[g], ip[g]);
                end else begin
                    w = wq[g].pop_front();
                    if (si[g] != w.addr || ip[g] != w.data) begin
                        errors++;
                        $display("FAIL write lane%0d addr=%0d data=%h required addr=%0d data=%h", g, si[g], ip[g], w.addr, w.data);
                    end
                end
            end
            if (rv[g]) begin
                if (!seen[g]) begin
                    seen[g]   = 1'b1;
                    tfirst[g] = cyc + 1;
                    hop[g]    = rop[g];
                    ha[g]     = ra[g];
                    hb[g]     = rb[g];
                end else begin
                    checks++;
                    if (rop[g] != hop[g] || ra[g] != ha[g] || rb[g] != hb[g] || rdy[g]) begin
                        errors++;
                        $display("FAIL rsp_hold lane%0d op=%0d a=%h b=%h ready=%b required op=%0d a=%h b=%h ready=0", g, rop[g], ra[g], rb[g], rdy[g], hop[g], ha[g], hb[g]);
                    end
                end
                if (rrdy) begin
                    seen[g] = 1'b0;
                    checks++;
                    if (eq[g].size() == 0) begin
                        errors++;
                        $display("FAIL rsp_extra lane%0d op=%0d a=%h required no response", g, rop[g], ra[g]);
                    end else begin
                        e = eq[g].pop_front();
                        if (rop[g] != e.op || ra[g] != e.a || rb[g] != e.b || tfirst[g] - e.tacc != e.lat) begin
                            errors++;
                            $display("FAIL rsp lane%0d op=%0d a=%h b=%h lat=%0d required op=%0d a=%h b=%h lat=%0d", g, rop[g], ra[g], rb[g], tfirst[g] - e.tacc, e.op, e.a, e.b, e.lat);
                        end
                    end
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic expw(input logic [3:0] addr, input logic [31:0] data);
        for (int g = 0; g < 2; g++) wq[g].push_back('{addr, data});
    endtask
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] ea, input logic [31:0] eb, input int lat);
        logic [1:0] done = 2'b00;
        c_op = op;
        c_a  = a;
        c_b  = b;
        c_d  = d;
        vld  = 2'b11;
        for (int n = 0; n < 200 && done != 2'b11; n++) begin
            for (int g = 0; g < 2; g++)
                if (!done[g] && rdy[g]) begin
                    done[g] = 1'b1;
                    eq[g].push_back('{op, ea, eb, cyc + 1, op == OP_READ2 ? 2 + (g == 0 ? 1 : 3) : lat});
                end
            tick();
            vld = vld & ~done;
        end
        vld = 2'b00;
        checks++;
        if (done != 2'b11) begin
            errors++;
            $display("FAIL accept op=%0d accepted=%b required 11", op, done);
        end
    endtask
    task automatic drain();
        int n = 0;
        while ((eq[0].size() != 0 || eq[1].size() != 0 || !rdy[0] || !rdy[1]) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200 || wq[0].size() != 0 || wq[1].size() != 0) begin
            errors++;
            $display("FAIL drain cycles=%0d pending_rsp=%0d/%0d pending_wr=%0d/%0d required all zero under 200", n, eq[0].size(), eq[1].size(), wq[0].size(), wq[1].size());
        end
    endtask
    task automatic chk_idle(input string name);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({rdy[g], bsy[g], rv[g], en[g], wr[g], rd[g]} != 6'b100000 || ip[g] != 0 || si[g] != 0 ||
                so1[g] != 0 || so2[g] != 0 || rop[g] != 0 || ra[g] != 0 || rb[g] != 0) begin
                errors++;
                $display("FAIL %s lane%0d rdy/busy/rv/en/wr/rd=%b%b%b%b%b%b ip=%h sel=%0d/%0d/%0d rsp=%0d/%h/%h required 100000 and all zero",
                         name, g, rdy[g], bsy[g], rv[g], en[g], wr[g], rd[g], ip[g], si[g], so1[g], so2[g], rop[g], ra[g], rb[g]);
            end
        end
    endtask
    initial begin
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle("reset");
        expw(4'd0, 32'hABCD_EFAB);
        issue(OP_WRITE, 4'd0, 4'd0, 32'hABCD_EFAB, 32'd1, 32'd0, 2);
        drain();
        issue(OP_READ2, 4'd0, 4'd0, 32'd0, 32'hABCD_EFAB, 32'hABCD_EFAB, 0);
        drain();
        expw(4'd1, 32'h0123_4567);
        issue(OP_WRITE, 4'd1, 4'd9, 32'h0123_4567, 32'd1, 32'd0, 2);
        drain();
        issue(OP_READ2, 4'd0, 4'd1, 32'd0, 32'hABCD_EFAB, 32'h0123_4567, 0);
        drain();
        issue(OP_READ2, 4'd1, 4'd0, 32'd0, 32'h0123_4567, 32'hABCD_EFAB, 0);
        drain();
        expw(4'd14, 32'hFFFF_FFFE);
        expw(4'd15, 32'hFFFF_FFFF);
        expw(4'd0, 32'h0000_0000);
        expw(4'd1, 32'h0000_0001);
        issue(OP_FILL, 4'd14, 4'd1, 32'hFFFF_FFFE, 32'd4, 32'd0, 5);
        drain();
        issue(OP_READ2, 4'd15, 4'd14, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        drain();
        expw(4'd5, 32'h0000_0055);
        issue(OP_FILL, 4'd5, 4'd5, 32'h0000_0055, 32'd1, 32'd0, 2);
        drain();
        for (int i = 0; i < 16; i++) expw(4'(i), 32'd0);
        rrdy = 1'b0;
        issue(OP_CLEAR, 4'd3, 4'd7, 32'hDEAD_0000, 32'd16, 32'd0, 17);
        for (int n = 0; n < 40 && !(rv[0] && rv[1]); n++) tick();
        repeat (3) tick();
        rrdy = 1'b1;
        drain();
        issue(OP_READ2, 4'd5, 4'd14, 32'd0, 32'd0, 32'd0, 0);
        drain();
        for (int i = 0; i < 16; i++) expw(4'(i), 32'd0);
        issue(OP_CLEAR, 4'd0, 4'd0, 32'd0, 32'd16, 32'd0, 17);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (wq[g].size() != 11) begin
                errors++;
                $display("FAIL abort_writes lane%0d remaining=%0d required 11", g, wq[g].size());
            end
            wq[g].delete();
            eq[g].delete();
        end
        chk_idle("abort");
        expw(4'd9, 32'h9999_0000);
        issue(OP_WRITE, 4'd9, 4'd0, 32'h9999_0000, 32'd1, 32'd0, 2);
        drain();
        issue(OP_READ2, 4'd9, 4'd2, 32'd0, 32'h9999_0000, 32'd0, 0);
        drain();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d required completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
